// File: rtl/sr_load_ctrl_pkg.sv
// Shared types for the shift-register load controller.
// State encoding and direction constants.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/sr_load_ctrl_if.sv
// Command handshake bundle between host and controller.
// Host drives valid/word/dir, controller returns ready.
interface sr_load_ctrl_if #(
  parameter int MSB = 16
);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [MSB-1:0] cmd_word;
  logic           cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_word,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_word,
    input  cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/sr_bit_cnt.sv
// Modulo-MSB bit counter with clear, enable and terminal count.
// Terminal count is a decode of the current value.
module sr_bit_cnt #(
  parameter  int MSB = 16,
  localparam int W   = $clog2(MSB)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == W'(MSB-1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sr_load_ctrl.sv
// Sequencer that serially loads a word into shift_reg and
// checks the result, reporting done/match/mismatch count.
module sr_load_ctrl
  import sr_pkg::*;
#(
  parameter int MSB   = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  sr_load_ctrl_if.slave    cmd,
  input  logic             abort,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_dir,
  input  logic [MSB-1:0]   sr_out,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int W = $clog2(MSB);

  state_e           state_q, state_d;
  logic [MSB-1:0]   word_q, word_d;
  logic             dir_q, dir_d;
  logic             sr_d_q, sr_d_d;
  logic             sr_en_q, sr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic [W-1:0] cnt;
  logic [W-1:0] nxt;
  logic         tc;
  logic         pick;

  sr_bit_cnt #(.MSB(MSB)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_q != SHIFT),
    .en   (state_q == SHIFT),
    .cnt  (cnt),
    .tc   (tc)
  );

  assign cmd.cmd_ready = (state_q == IDLE);
  assign sr_d          = sr_d_q;
  assign sr_en         = sr_en_q;
  assign sr_dir        = dir_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign match         = match_q;
  assign mismatch_cnt  = mcnt_q;

  // Outputs are registered, so pick the bit for the next cycle.
  assign nxt  = cnt + W'(1);
  assign pick = (dir_q == DIR_RIGHT) ? word_q[nxt]
                                     : word_q[W'(MSB-1) - nxt];

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dir_d   = dir_q;
    sr_d_d  = 1'b0;
    sr_en_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    match_d = match_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_d = SHIFT;
          word_d  = cmd.cmd_word;
          dir_d   = cmd.cmd_dir;
          sr_en_d = 1'b1;
          busy_d  = 1'b1;
          sr_d_d  = (cmd.cmd_dir == DIR_RIGHT)
                    ? cmd.cmd_word[0]
                    : cmd.cmd_word[MSB-1];
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tc) begin
          state_d = CHECK;
          busy_d  = 1'b1;
        end else begin
          sr_en_d = 1'b1;
          busy_d  = 1'b1;
          sr_d_d  = pick;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = REPORT;
          match_d = (sr_out == word_q);
          done_d  = 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
        if (!match_q && (mcnt_q != {CNT_W{1'b1}})) begin
          mcnt_d = mcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      dir_q   <= DIR_LEFT;
      sr_d_q  <= 1'b0;
      sr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      sr_d_q  <= sr_d_d;
      sr_en_q <= sr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule

// File: doc/sr_load_ctrl.md
Name: sr_load_ctrl

Overview:
Command-driven sequencer for shift_reg (parameter MSB). It accepts a parallel word and a shift direction over a valid/ready handshake. It then drives shift_reg's d/en/dir pins for exactly MSB clocks so the word is serially loaded, and compares shift_reg's out against the word. It reports done, match and a saturating mismatch count, and sits between a host/register block and the shift_reg instance.

Parameters:
MSB, 16, shift register width in bits; legal range 2..64
CNT_W, 8, width of saturating mismatch counter

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous, active-high reset (asserted = 1)
cmd_valid  input  1  host presents command
cmd_ready  output  1  controller can accept command (high only in IDLE)
cmd_word  input  MSB  word to load
cmd_dir  input  1  0 = left shift (d enters bit 0), 1 = right shift (d enters bit MSB-1)
abort  input  1  cancel in-flight command
sr_d  output  1  serial data to shift_reg.d
sr_en  output  1  shift enable to shift_reg.en
sr_dir  output  1  direction to shift_reg.dir
sr_out  input  MSB  shift_reg.out
busy  output  1  high in SHIFT or CHECK
done  output  1  one-cycle pulse on command completion
match  output  1  result of last completed compare, valid when done=1, held until next done
mismatch_cnt  output  CNT_W  count of completed commands with match=0, saturates at all-ones

Behaviour:
- Reset values (async, immediate): state=IDLE; cmd_ready=1; sr_d=0; sr_en=0; sr_dir=0; busy=0; done=0; match=0; mismatch_cnt=0; bit counter=0.
- All outputs are registered except cmd_ready, which decodes state==IDLE.
- States: IDLE, SHIFT, CHECK, REPORT.
- IDLE: when cmd_valid & cmd_ready at edge T, latch cmd_word into word_q and cmd_dir into dir_q, then go to SHIFT. cmd_valid without ready is ignored.
- SHIFT occupies cycles T+1..T+MSB:
  - sr_en=1; sr_dir=dir_q.
  - dir_q=0: sr_d presents word_q[MSB-1] first, down to word_q[0].
  - dir_q=1: sr_d presents word_q[0] first, up to word_q[MSB-1].
  - Bit counter runs 0..MSB-1 and is $clog2(MSB) bits wide. Terminal count moves to CHECK.
- CHECK occupies cycle T+MSB+1: sr_en=0, sr_d=0, sr_dir held. Compare sr_out==word_q and register the result into match at the end of the cycle.
- REPORT occupies cycle T+MSB+2: done=1. If match=0, mismatch_cnt increments unless it is already all-ones. Next state is IDLE.
- Command-to-done latency is MSB+2 cycles; throughput is one command per MSB+3 cycles.
- sr_dir keeps the last commanded direction in IDLE. sr_d=0 and sr_en=0 whenever not in SHIFT.
- abort=1 in SHIFT or CHECK: next state is IDLE. sr_en drops on the next edge, no done is issued, and match and mismatch_cnt are unchanged. abort in IDLE or REPORT is ignored; REPORT completes normally.
- A cmd_valid that coincides with abort in IDLE is accepted (abort ignored in IDLE).
- cmd_word and cmd_dir changes while busy have no effect on the in-flight command.
- rstn asserted mid-command immediately returns to IDLE with reset values. The shift_reg contents are not restored.

Decomposition:
- Shared package sr_pkg holds:
  - state enum: IDLE=2'd0, SHIFT=2'd1, CHECK=2'd2, REPORT=2'd3
  - direction constants: DIR_LEFT=1'b0, DIR_RIGHT=1'b1
- One sub-module, sr_bit_cnt: a modulo-MSB counter with clear, enable and terminal-count output. It is instantiated once.
- The compare and saturating counter stay in the top module.

Test Plan:
All scenarios use MSB=16 and a real shift_reg #(16) instance.
1. Reset: pulse rstn high mid-SHIFT -> all outputs return to reset values immediately; cmd_ready=1 the same cycle.
2. Left load: cmd 0xA5C3, dir=0 accepted at T -> sr_en high for exactly T+1..T+16; sr_d = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; done at T+18; match=1; sr_out=0xA5C3.
3. Right load: cmd 0x0001, dir=1 -> sr_d=1 in the first SHIFT cycle then 0; sr_dir=1 throughout; done at T+18; match=1; sr_out=0x0001.
4. Mismatch: bench forces sr_out bit 3 stuck at 0 during cmd 0xFFFF -> match=0 with done; mismatch_cnt 0->1. Repeat 256 times with CNT_W=8 -> saturates at 0xFF.
5. Abort: assert abort at T+5 of a dir=0 command -> sr_en low from T+6, no done pulse, cmd_ready=1 at T+6. A new command is accepted at T+6 and completes with done at T+6+18, match=1.
6. Back-to-back: cmd_valid held high with two words 0x1234 then 0xBEEF -> second accepted at T+19; cmd_ready low T+1..T+18; both done pulses with match=1.
